// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared types and constants for the program sequencer
// Contents: ps_state_t FSM encoding, PC_W / PS_PAGE_W widths, page_target() helper.
package program_sequencer_pkg;

    localparam int PC_W      = 8;
    localparam int PS_PAGE_W = 4;

    typedef enum logic [1:0] {
        PS_RESET = 2'd0,
        PS_RUN   = 2'd1,
        PS_HOLD  = 2'd2
    } ps_state_t;

    // Jumps stay inside the current 16-word page: keep the page bits of pc.
    function automatic logic [PC_W-1:0] page_target(
        input logic [PC_W-1:0]      cur_pc,
        input logic [PS_PAGE_W-1:0] nibble
    );
        return {cur_pc[PC_W-1:PS_PAGE_W], nibble};
    endfunction

endpackage

// File: rtl/program_sequencer_return_stack.sv
// rtl/program_sequencer_return_stack.sv - subroutine return-address stack (PS_CALL_STACK_EN builds)
// Ports: clk, sync_reset (sync, active-high), push/din write the next free slot,
//        pop drops the top, dout is the current top (combinational), depth is the
//        registered occupancy, overflow/underflow flag a push when full / pop when empty.
// Pushes when full and pops when empty are dropped. Push and pop together are not
// arbitrated here; push wins, and the sequencer never issues both.
`ifdef PS_CALL_STACK_EN
import program_sequencer_pkg::*;

module return_stack #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic            clk,
    input  logic            sync_reset,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic [CW-1:0]   depth,
    output logic            overflow,
    output logic            underflow
);

    logic [PC_W-1:0] mem [DEPTH];
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;
    logic [AW-1:0]   top_idx;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign overflow  = push & full;
    assign underflow = pop & empty;
    assign top_idx   = AW'(count - CW'(1));
    assign dout      = mem[top_idx];
    assign depth     = count;

    // Storage carries no reset; only entries below count are ever read.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[AW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

endmodule
`endif

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch stage: program counter, next-address mux and run/hold FSM
// Ports: clk, sync_reset (sync, active-high); jmp, jmp_nz, jmp_addr, dont_jmp from
//        decoder/ALU; hold stalls and refetches; call/ret used only with PS_CALL_STACK_EN.
//        pm_addr is the combinational next PC, pc the registered PC tagging the IR,
//        running is 1 in RUN, stack_depth / stack_err report return-stack state.
// Optional feature macro: PS_CALL_STACK_EN (return stack, call/ret handling).
import program_sequencer_pkg::*;

module program_sequencer #(
    parameter int STACK_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 sync_reset,
    input  logic                 jmp,
    input  logic                 jmp_nz,
    input  logic [PS_PAGE_W-1:0] jmp_addr,
    input  logic                 dont_jmp,
    input  logic                 hold,
    input  logic                 call,
    input  logic                 ret,
    output logic [PC_W-1:0]      pm_addr,
    output logic [PC_W-1:0]      pc,
    output logic                 running,
    output logic [2:0]           stack_depth,
    output logic                 stack_err
);

    ps_state_t       state;
    ps_state_t       state_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] target;

    assign pc_inc = pc + PC_W'(1);
    assign target = page_target(pc, jmp_addr);

`ifdef PS_CALL_STACK_EN
    localparam int RS_CW = $clog2(STACK_DEPTH) + 1;

    logic             rs_push;
    logic             rs_pop;
    logic [PC_W-1:0]  rs_dout;
    logic [RS_CW-1:0] rs_depth;
    logic             rs_overflow;
    logic             rs_underflow;
    logic [3:0]       depth_ext;
    logic             err_q;

    return_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk        (clk),
        .sync_reset (sync_reset),
        .push       (rs_push),
        .pop        (rs_pop),
        .din        (pc_inc),
        .dout       (rs_dout),
        .depth      (rs_depth),
        .overflow   (rs_overflow),
        .underflow  (rs_underflow)
    );

    // A full 8-entry stack does not fit the 3-bit output; it reads as 7.
    assign depth_ext   = 4'(rs_depth);
    assign stack_depth = depth_ext[3] ? 3'd7 : depth_ext[2:0];
    assign stack_err   = err_q;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            err_q <= 1'b0;
        end else if (rs_overflow || rs_underflow) begin
            err_q <= 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg  = ^{call, ret, 32'(STACK_DEPTH)};
    assign stack_depth = 3'd0;
    assign stack_err   = 1'b0;
`endif

    // Next-address priority: reset, hold, ret, call, jmp, jmp_nz, increment.
    always_comb begin
        pm_addr = pc_inc;
`ifdef PS_CALL_STACK_EN
        rs_push = 1'b0;
        rs_pop  = 1'b0;
`endif
        if (sync_reset) begin
            pm_addr = '0;
        end else if (hold) begin
            pm_addr = pc;
        end else begin
`ifdef PS_CALL_STACK_EN
            if (ret) begin
                // Pop is issued even when empty so the stack reports underflow;
                // an empty return simply continues at pc+1.
                rs_pop  = 1'b1;
                pm_addr = (rs_depth == '0) ? pc_inc : rs_dout;
            end else if (call) begin
                rs_push = 1'b1;
                pm_addr = target;
            end else
`endif
            if (jmp) begin
                pm_addr = target;
            end else if (jmp_nz && !dont_jmp) begin
                pm_addr = target;
            end
        end
    end

    always_comb begin
        state_d = state;
        if (sync_reset) begin
            state_d = PS_RESET;
        end else begin
            case (state)
                PS_RESET: state_d = PS_RUN;
                PS_RUN:   state_d = hold ? PS_HOLD : PS_RUN;
                PS_HOLD:  state_d = hold ? PS_HOLD : PS_RUN;
                default:  state_d = PS_RESET;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            pc      <= '0;
            state   <= PS_RESET;
            running <= 1'b0;
        end else begin
            pc      <= pm_addr;
            state   <= state_d;
            running <= (state_d == PS_RUN);
        end
    end

endmodule
